// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: operation encodings and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_shifter.sv
// Bit-serial shifter: latches an operand and shift amount, then moves one bit per
// cycle until the count runs out. Unused when ITERATIVE_ALU_BARREL_EN is defined.
module serial_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             left,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] next_data,
  output logic             last
);

  logic [WIDTH-1:0] data_p0;
  logic             left_p0;
  logic [SHW-1:0]   count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= shamt;
    else if (count != '0)
      count <= count - SHW'(1);
  end

  // Datapath registers carry no reset; the count alone decides when they are live.
  always_ff @(posedge clk) begin
    if (load) begin
      data_p0 <= operand;
      left_p0 <= left;
    end else if (count != '0) begin
      data_p0 <= next_data;
    end
  end

  assign next_data = left_p0 ? {data_p0[WIDTH-2:0], 1'b0} : {1'b0, data_p0[WIDTH-1:1]};
  assign last      = (count == SHW'(1));

endmodule

// File: rtl/iterative_alu.sv
// Single-issue ALU: most ops finish in one cycle; shifts run bit-serially unless
// ITERATIVE_ALU_BARREL_EN is defined, in which case they also finish in one cycle.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  alu_op_t          op;
  logic             go_serial;
  logic             load, fin_fast, fin_shift;
  logic             shift_last;
  logic [WIDTH-1:0] shift_next;

  function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input alu_op_t o);
    logic signed [WIDTH-1:0] sa, sb;
    sa = a;
    sb = b;
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLL:  return a << b[SHW-1:0];
      OP_SRL:  return a >> b[SHW-1:0];
      default: return '0;
    endcase
  endfunction

  assign op = alu_op_t'(ALUControl);

`ifdef ITERATIVE_ALU_BARREL_EN
  assign go_serial  = 1'b0;
  assign shift_last = 1'b0;
  assign shift_next = '0;
`else
  logic is_shift;
  assign is_shift  = (op == OP_SLL) || (op == OP_SRL);
  // A zero shift amount completes on the single-cycle path.
  assign go_serial = is_shift && (SrcB[SHW-1:0] != '0);

  serial_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .left      (op == OP_SLL),
    .operand   (SrcA),
    .shamt     (SrcB[SHW-1:0]),
    .next_data (shift_next),
    .last      (shift_last)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fin_fast  = 1'b0;
    fin_shift = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (go_serial) begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end else begin
            fin_fast = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (shift_last) begin
          fin_shift = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result stage: written only on completion and held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      ALUResult <= '0;
    end else begin
      done <= fin_fast | fin_shift;
      if (fin_fast)
        ALUResult <= alu_eval(SrcA, SrcB, op);
      else if (fin_shift)
        ALUResult <= shift_next;
    end
  end

  assign busy = (state == SHIFT);
  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: one-cycle ops, serial shifts, back-to-back issue and reset abort.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic        busy, done, Zero;
  logic [31:0] ALUResult;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int nbusy;
  int ndone;

`ifdef ITERATIVE_ALU_BARREL_EN
  localparam int SLL31_LAT = 1;
  localparam int SRL4_LAT  = 1;
`else
  localparam int SLL31_LAT = 32;
  localparam int SRL4_LAT  = 5;
`endif

  iterative_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    start      = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    SrcA = '0;
    SrcB = '0;
    ALUControl = 3'b000;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", ALUResult, 32'h0);
    chk("rst_zero", 32'(Zero), 32'd1);
    reset = 1'b0;
    step();

    issue(3'b000, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_done", 32'(done), 32'd1);
    chk("add_wrap_res", ALUResult, 32'h0);
    chk("add_wrap_zero", 32'(Zero), 32'd1);
    chk("add_wrap_busy", 32'(busy), 32'd0);
    step();
    chk("add_done_pulse", 32'(done), 32'd0);

    issue(3'b001, 32'd5, 32'd7);
    chk("sub_res", ALUResult, 32'hFFFF_FFFE);
    chk("sub_zero", 32'(Zero), 32'd0);

    issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("and_res", ALUResult, 32'hF000_F000);
    issue(3'b011, 32'h0F0F_0000, 32'h0000_00F0);
    chk("or_res", ALUResult, 32'h0F0F_00F0);

    issue(3'b101, 32'h8000_0000, 32'h1);
    chk("slt_neg_lt_pos", ALUResult, 32'h1);
    issue(3'b101, 32'h1, 32'h8000_0000);
    chk("slt_pos_lt_neg", ALUResult, 32'h0);
    chk("slt_zero_flag", 32'(Zero), 32'd1);

    issue(3'b110, 32'h1, 32'd31);
    cyc = 1;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy === 1'b1) nbusy++;
      step();
      cyc++;
    end
    chk("sll31_latency", 32'(cyc), 32'(SLL31_LAT));
    chk("sll31_busy_cycles", 32'(nbusy), 32'(SLL31_LAT - 1));
    chk("sll31_res", ALUResult, 32'h8000_0000);
    chk("sll31_busy_clear", 32'(busy), 32'd0);

    issue(3'b111, 32'h8000_0000, 32'd4);
    cyc = 1;
`ifndef ITERATIVE_ALU_BARREL_EN
    chk("srl_busy", 32'(busy), 32'd1);
    SrcA = 32'hFFFF_FFFF;
    SrcB = 32'h1;
    ALUControl = 3'b000;
    start = 1'b1;
    step();
    cyc++;
    chk("srl_start_ignored_done", 32'(done), 32'd0);
    step();
    cyc++;
    start = 1'b0;
`endif
    while (done !== 1'b1 && cyc < 64) begin
      step();
      cyc++;
    end
    chk("srl4_latency", 32'(cyc), 32'(SRL4_LAT));
    chk("srl4_res", ALUResult, 32'h0800_0000);
    step();
    chk("srl4_no_extra_done", 32'(done), 32'd0);
    chk("srl4_res_held", ALUResult, 32'h0800_0000);

    issue(3'b000, 32'd3, 32'd4);
    chk("b2b_add_res", ALUResult, 32'd7);
    chk("b2b_add_done", 32'(done), 32'd1);
    ALUControl = 3'b100;
    SrcA = 32'hFF00_FF00;
    SrcB = 32'h0FF0_0FF0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_xor_done", 32'(done), 32'd1);
    chk("b2b_xor_res", ALUResult, 32'hF0F0_F0F0);
    step();
    chk("b2b_xor_pulse_end", 32'(done), 32'd0);

    issue(3'b110, 32'h1234_5678, 32'h20);
    chk("sll0_done", 32'(done), 32'd1);
    chk("sll0_res", ALUResult, 32'h1234_5678);
    chk("sll0_busy", 32'(busy), 32'd0);

    issue(3'b110, 32'h1, 32'd20);
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", ALUResult, 32'h0);
    chk("abort_zero", 32'(Zero), 32'd1);
    step();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    issue(3'b011, 32'h0000_0100, 32'h0000_0001);
    chk("post_reset_or", ALUResult, 32'h0000_0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, 32, operand and result width in bits.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request to launch an operation; accepted only when busy is 0.
REQ-006 Port: SrcA  input  WIDTH  first operand; sampled on accept.
REQ-007 Port: SrcB  input  WIDTH  second operand; SrcB[$clog2(WIDTH)-1:0] is the shift amount; sampled on accept.
REQ-008 Port: ALUControl  input  3  operation code from the ALU decoder; sampled on accept.
REQ-009 Port: busy  output  1  multi-cycle operation in progress.
REQ-010 Port: done  output  1  one-cycle pulse; ALUResult and Zero valid from this cycle on.
REQ-011 Port: ALUResult  output  WIDTH  registered result, held until the next done.
REQ-012 Port: Zero  output  1  ALUResult equals 0.

Function
REQ-013 Encoding SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl (logical).
REQ-014 add/sub SHALL wrap modulo 2^WIDTH; slt SHALL return 1 or 0 zero-extended.
REQ-015 FSM states SHALL be IDLE and SHIFT; reset enters IDLE.
REQ-016 IDLE, start=1, non-shift op: ALUResult registered at the next edge, done=1 for that one cycle, stay IDLE (latency 1).
REQ-017 IDLE, start=1, shift op with shamt=0: result = SrcA, latency 1, SHIFT not entered.
REQ-018 IDLE, start=1, shift op with shamt>0: latch operand, counter=shamt, go to SHIFT, busy=1.
REQ-019 SHIFT: shift one bit per cycle and decrement counter; on counter reaching 0, register result, pulse done, clear busy, return to IDLE; total latency shamt+1 cycles.
REQ-020 start while busy=1 SHALL be ignored with no effect on state or operands.
REQ-021 start in the same cycle as done with busy=0 SHALL be accepted (back-to-back issue).
REQ-022 Input changes after accept SHALL NOT affect an in-flight operation.
REQ-023 Zero SHALL be updated in the same cycle as ALUResult.

Reset
REQ-024 Reset SHALL force: state IDLE, busy=0, done=0, ALUResult=0, Zero=1, counter=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro ITERATIVE_ALU_BARREL_EN defined: shifts SHALL complete in 1 cycle like other ops; SHIFT is never entered; busy stays 0.
REQ-027 Macro undefined: shifts SHALL be bit-serial per REQ-018/019.

Structure
REQ-028 Package alu_pkg SHALL hold the alu_op_t 3-bit enum (REQ-013 encodings) and the FSM state typedef.
REQ-029 Sub-module serial_shifter SHALL implement the latched operand, counter, and per-cycle shift; it is omitted under ITERATIVE_ALU_BARREL_EN.

Verification
REQ-030 Reset mid-SHIFT (sll, shamt 20, reset at cycle 5) -> busy=0, done never pulses, ALUResult=0, Zero=1.
REQ-031 add 0xFFFFFFFF+1 -> done after 1 cycle, ALUResult=0, Zero=1; sub 5-7 -> 0xFFFFFFFE, Zero=0.
REQ-032 slt SrcA=0x80000000, SrcB=1 -> ALUResult=1; swapped operands -> 0.
REQ-033 sll SrcA=1, SrcB=31 (serial) -> busy for 31 cycles, done at cycle 32, ALUResult=0x80000000; with macro -> done at cycle 1.
REQ-034 srl SrcA=0x80000000, SrcB=4 with start pulsed and SrcA changed while busy -> ALUResult=0x08000000 at cycle 5; extra start ignored.
REQ-035 xor issued in the done cycle of a previous add -> accepted, second done exactly one cycle later.
